// File: rtl/wr_stream_adapter.sv
// rtl/wr_stream_adapter.sv - write-side stream ingress for the async FIFO
// Optional stall statistics counter enabled by defining WR_ADAPT_STATS_EN.
module wr_stream_adapter #(
  parameter int data_width   = 8,
  parameter int ptr_size     = 4,
  parameter int afull_thresh = 12
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [data_width-1:0] s_data,
  output logic                  s_ready,
  input  logic                  full,
  input  logic [ptr_size:0]     b_wptr,
  input  logic [ptr_size:0]     g_rptr_sync,
  output logic                  wr_en,
  output logic [data_width-1:0] wr_data,
  output logic [ptr_size:0]     wr_level,
  output logic                  almost_full,
  output logic [15:0]           stall_cnt
);

  localparam logic [ptr_size+1:0] afull_lim = (ptr_size+2)'(afull_thresh);

  logic [1:0]            cnt, cnt_next;
  logic [data_width-1:0] ent0, ent1, ent0_next, ent1_next;
  logic                  accept, write;
  logic [ptr_size:0]     rptr_bin, rptr_dec, diff;

  assign wr_en   = (cnt != 2'd0) && !full;
  assign write   = wr_en;
  assign accept  = s_valid && s_ready;
  assign wr_data = ent0;

  // ent0 is always the head; a new beat lands in slot cnt_next-1
  always_comb begin
    ent0_next = ent0;
    ent1_next = ent1;
    cnt_next  = cnt + {1'b0, accept} - {1'b0, write};
    if (write)
      ent0_next = ent1;
    if (accept) begin
      if (cnt_next == 2'd1)
        ent0_next = s_data;
      else
        ent1_next = s_data;
    end
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      cnt     <= 2'd0;
      ent0    <= '0;
      ent1    <= '0;
      s_ready <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      ent0    <= ent0_next;
      ent1    <= ent1_next;
      s_ready <= (cnt_next < 2'd2);
    end
  end

  always_comb begin
    rptr_dec = '0;
    for (int i = 0; i <= ptr_size; i++)
      rptr_dec[i] = ^(g_rptr_sync >> i);
  end

  // modular subtraction absorbs pointer wrap
  assign diff = b_wptr - rptr_bin;

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      rptr_bin    <= '0;
      wr_level    <= '0;
      almost_full <= 1'b0;
    end else begin
      rptr_bin    <= rptr_dec;
      wr_level    <= diff;
      almost_full <= ({1'b0, diff} >= afull_lim);
    end
  end

`ifdef WR_ADAPT_STATS_EN
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst)
      stall_cnt <= 16'd0;
    else if (s_valid && !s_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_wr_stream_adapter.sv
// tb/tb_wr_stream_adapter.sv - randomized bench for wr_stream_adapter against a queue model
module tb_wr_stream_adapter;

`ifdef WR_ADAPT_STATS_EN
  localparam bit stats = 1'b1;
`else
  localparam bit stats = 1'b0;
`endif

  logic        wr_clk, rst, s_valid, s_ready, full, wr_en, almost_full;
  logic [7:0]  s_data, wr_data;
  logic [4:0]  b_wptr, g_rptr_sync, wr_level;
  logic [15:0] stall_cnt;

  wr_stream_adapter #(.data_width(8), .ptr_size(4), .afull_thresh(12)) dut (
    .wr_clk(wr_clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .full(full), .b_wptr(b_wptr), .g_rptr_sync(g_rptr_sync), .wr_en(wr_en),
    .wr_data(wr_data), .wr_level(wr_level), .almost_full(almost_full), .stall_cnt(stall_cnt)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  q[$];
  logic        sr_m, af_m, last_acc;
  logic [4:0]  lvl_m, rb_m;
  logic [15:0] st_m;
  int          nwr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] gray_to_bin(input logic [4:0] g);
    logic [4:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    return b;
  endfunction

  task automatic model_reset();
    q.delete();
    sr_m  = 1'b0;
    af_m  = 1'b0;
    lvl_m = 5'd0;
    rb_m  = 5'd0;
    st_m  = 16'd0;
  endtask

  task automatic step();
    logic exp_en, acc;
    @(negedge wr_clk);
    exp_en = (q.size() != 0) && !full;
    check("s_ready", s_ready, sr_m);
    check("wr_en", wr_en, exp_en);
    if (exp_en) check("wr_data", wr_data, q[0]);
    check("wr_level", wr_level, lvl_m);
    check("almost_full", almost_full, af_m);
    check("stall_cnt", stall_cnt, st_m);
    acc = s_valid && sr_m;
    if (stats && s_valid && !sr_m && st_m != 16'hFFFF) st_m = st_m + 16'd1;
    if (exp_en) begin
      void'(q.pop_front());
      nwr++;
    end
    if (acc) q.push_back(s_data);
    sr_m     = (q.size() < 2);
    lvl_m    = b_wptr - rb_m;
    af_m     = (lvl_m >= 5'd12);
    rb_m     = gray_to_bin(g_rptr_sync);
    last_acc = acc;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_wr_level", wr_level, 0);
    check("rst_almost_full", almost_full, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_wr_data", wr_data, 0);
    model_reset();
    @(posedge wr_clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int d;
    rst = 1'b0; s_valid = 1'b0; s_data = 8'd0; full = 1'b0;
    b_wptr = 5'd0; g_rptr_sync = 5'd0;
    last_acc = 1'b0; nwr = 0;
    model_reset();
    #2;
    do_reset();

    // continuous stream 0x01..0x10
    d = 1;
    for (int c = 0; c < 20; c++) begin
      s_valid = (d <= 16);
      s_data  = 8'(d);
      step();
      if (last_acc) d++;
    end
    s_valid = 1'b0;
    step();
    step();
    check("stream_writes", nwr, 16);

    // backpressure from full, 10 cycles from reset release
    do_reset();
    s_valid = 1'b1;
    full    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      s_data = 8'($urandom);
      step();
    end
    check("hold_s_ready", s_ready, 0);
    check("hold_wr_en", wr_en, 0);
    check("hold_stall", stall_cnt, stats ? 8 : 0);
    s_valid = 1'b0;
    full    = 1'b0;
    for (int c = 0; c < 4; c++) step();

    // level and almost_full
    b_wptr = 5'b01100; g_rptr_sync = 5'd0;
    step(); step();
    check("lvl12", wr_level, 12);
    check("af12", almost_full, 1);
    g_rptr_sync = 5'd1;
    step(); step();
    check("lvl11", wr_level, 11);
    check("af11", almost_full, 0);
    b_wptr = 5'b00010; g_rptr_sync = 5'b11101;
    step(); step();
    check("lvl_wrap", wr_level, 12);
    b_wptr = 5'b01100; g_rptr_sync = 5'd0;
    step(); step();

    // reset with two beats buffered
    full = 1'b1; s_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      s_data = 8'hA0 + 8'(c);
      step();
    end
    do_reset();
    full = 1'b0; s_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      s_valid     = ($urandom_range(0, 3) != 0);
      s_data      = 8'($urandom);
      full        = ($urandom_range(0, 3) == 0);
      b_wptr      = 5'($urandom);
      g_rptr_sync = 5'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wr_stream_adapter.md
# wr_stream_adapter

Write-side ingress stage of the asynchronous FIFO, in the wr_clk domain directly upstream of the write-pointer block. Accepts a valid/ready data stream through a 2-entry skid buffer and drives wr_en/wr_data into the FIFO, honouring the write-pointer block's registered full flag. Also computes the write-side fill level and almost-full flag from the local binary write pointer and the synchronized Gray read pointer.

## Interface
- data_width, 8, width of stream and FIFO data
- ptr_size, 4, FIFO address width; FIFO depth = 2^ptr_size; pointers are ptr_size+1 bits
- afull_thresh, 12, almost_full asserts when fill level >= this value; legal range 1..2^ptr_size

- wr_clk  in  1  write-domain clock
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  upstream beat valid
- s_data  in  data_width  upstream beat data
- s_ready  out  1  adapter can accept a beat (registered)
- full  in  1  registered full flag from the write-pointer block
- b_wptr  in  ptr_size+1  binary write pointer from the write-pointer block
- g_rptr_sync  in  ptr_size+1  Gray read pointer, already 2-FF synchronized into wr_clk
- wr_en  out  1  write request to the write-pointer block and FIFO memory
- wr_data  out  data_width  data for the FIFO memory write port
- wr_level  out  ptr_size+1  registered fill level, 0..2^ptr_size
- almost_full  out  1  registered, wr_level >= afull_thresh
- stall_cnt  out  16  stall statistics (see Configuration)

## Operation
- Skid buffer: 2 entries, in-order, occupancy cnt in 0..2; head entry drives wr_data.
- accept = s_valid && s_ready; write = wr_en.
- wr_en = (cnt != 0) && !full, combinational; a beat leaves the buffer only when write = 1 at a wr_clk edge.
- cnt_next = cnt + accept - write; accept and write in the same cycle are both legal.
- s_ready <= (cnt_next < 2); s_ready never asserts while cnt == 2.
- s_data is captured only on accept; no beat is dropped or duplicated; order preserved.
- full = 1: wr_en held 0, buffer retains contents, wr_data stable.
- Level: rptr_bin <= Gray-to-binary(g_rptr_sync) (bit i = XOR of bits ptr_size..i).
- diff = (b_wptr - rptr_bin) mod 2^(ptr_size+1); pointer wrap handled by modular subtraction.
- wr_level <= diff; almost_full <= (diff >= afull_thresh).
- Reset values: s_ready 0, wr_en 0, wr_data 0, cnt 0, buffer entries 0, rptr_bin 0, wr_level 0, almost_full 0, stall_cnt 0.
- Reset mid-operation: buffered beats discarded; all state returns to reset values immediately (asynchronous).

## Timing
- s_ready rises at the first wr_clk edge after rst deasserts.
- Latency: beat accepted at edge N is on wr_data with wr_en = 1 during cycle N+1 (if !full); written at edge N+1.
- Sustained throughput: 1 beat/cycle while full = 0.
- full rising: wr_en drops in the same cycle full is observed high; at most 2 beats remain buffered.
- wr_level/almost_full: 1 cycle after b_wptr change; 2 cycles after g_rptr_sync change.
- wr_level is pessimistic (read side may be further ahead); never under-reports occupancy.

## Configuration
- WR_ADAPT_STATS_EN defined: stall_cnt is a 16-bit counter incrementing each cycle with s_valid && !s_ready, saturating at 16'hFFFF, cleared only by rst.
- Not defined: counter logic omitted; stall_cnt tied to 0; port list unchanged.

## Test plan
- Reset then stream 0x01..0x10 continuously, full = 0 -> s_ready = 1 after first edge, one wr_en per cycle, wr_data 0x01..0x10 in order, each one cycle after acceptance.
- Hold full = 1 with s_valid = 1 -> two beats accepted, s_ready = 0 thereafter, wr_en = 0; release full -> both beats written in order, s_ready returns to 1 one cycle later.
- b_wptr = 5'b01100, g_rptr_sync = Gray(0) -> wr_level = 12, almost_full = 1 after 2 cycles; change g_rptr_sync to Gray(1) -> wr_level = 11, almost_full = 0.
- Wrap: b_wptr = 5'b00010, rptr = 5'b10110 (g_rptr_sync = 5'b11101) -> wr_level = 12.
- Assert rst with 2 beats buffered -> wr_en, s_ready, wr_level, almost_full go 0 immediately; after release, the old beats never appear on wr_data.
- With WR_ADAPT_STATS_EN, hold full = 1 and s_valid = 1 for 10 cycles -> stall_cnt = 8 (cycles with s_ready = 0); without macro stall_cnt = 0.
